// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- decoded-control pipeline with per-stage stall/flush and a multi-cycle stage-0 hold FSM.
// Rev 1.0
`default_nettype none

module ctrl_pipe #(
   parameter int SIGW   = 9,
   parameter int AUXW   = 3,
   parameter int NST    = 3,
   parameter int MC_BIT = 8,
   parameter int MCW    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SIGW-1:0]     sigs_d,
   input  logic [AUXW-1:0]     aux_d,
   input  logic [MCW-1:0]      mc_len_d,
   input  logic                valid_d,
   input  logic [NST-1:0]      stall_i,
   input  logic [NST-1:0]      flush_i,
   output logic [NST*SIGW-1:0] sigs_q,
   output logic [AUXW-1:0]     aux_q,
   output logic [NST-1:0]      valid_q,
   output logic                stall_up_o,
   output logic                busy_o
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [MCW-1:0]  cnt_q;
   logic [MCW-1:0]  cnt_d;

   logic [SIGW-1:0] sig_r [NST];
   logic [NST-1:0]  valid_r;
   logic [AUXW-1:0] aux_r;

   logic [NST-1:0]  hold;
   logic            busy;
   logic            load0;

   assign busy = (state_q == BUSY);

   // hold_k is the OR of every downstream stall; written non-recursively to keep the net acyclic
   always_comb begin
      hold = '0;
      for (int k = 0; k < NST; k++) begin
         for (int j = 0; j < NST; j++) begin
            if (j >= k) begin
               hold[k] = hold[k] | stall_i[j];
            end
         end
      end
      hold[0] = hold[0] | busy;
   end

   assign load0 = ~flush_i[0] & ~hold[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NST; k++) begin
            sig_r[k] <= '0;
         end
         valid_r <= '0;
         aux_r   <= '0;
      end else begin
         if (flush_i[0]) begin
            valid_r[0] <= 1'b0;
            sig_r[0]   <= '0;
            aux_r      <= '0;
         end else if (!hold[0]) begin
            valid_r[0] <= valid_d;
            sig_r[0]   <= valid_d ? sigs_d : '0;
            aux_r      <= valid_d ? aux_d : '0;
         end

         for (int k = 1; k < NST; k++) begin
            if (flush_i[k]) begin
               valid_r[k] <= 1'b0;
               sig_r[k]   <= '0;
            end else if (!hold[k]) begin
               if (hold[k-1]) begin
                  valid_r[k] <= 1'b0;
                  sig_r[k]   <= '0;
               end else begin
                  valid_r[k] <= valid_r[k-1];
                  sig_r[k]   <= valid_r[k-1] ? sig_r[k-1] : '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Only a fresh stage-0 load arms; the held instruction cannot re-arm because busy holds stage 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (load0 && valid_d && sigs_d[MC_BIT] && (mc_len_d > MCW'(1))) begin
               state_d = BUSY;
               cnt_d   = mc_len_d - MCW'(1);
            end
         end
         BUSY: begin
            if (flush_i[0] || (cnt_q == MCW'(1))) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - MCW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   generate
      for (genvar g = 0; g < NST; g++) begin : g_out
         assign sigs_q[g*SIGW +: SIGW] = sig_r[g];
      end
   endgenerate

   assign aux_q      = aux_r;
   assign valid_q    = valid_r;
   assign stall_up_o = hold[0];
   assign busy_o     = busy;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- directed self-checking bench for ctrl_pipe with default parameters.
// Rev 1.0
`default_nettype none

module tb_ctrl_pipe;

   logic        clk;
   logic        rst;
   logic [8:0]  sigs_d;
   logic [2:0]  aux_d;
   logic [5:0]  mc_len_d;
   logic        valid_d;
   logic [2:0]  stall_i;
   logic [2:0]  flush_i;
   logic [26:0] sigs_q;
   logic [2:0]  aux_q;
   logic [2:0]  valid_q;
   logic        stall_up_o;
   logic        busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   ctrl_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .sigs_d     (sigs_d),
      .aux_d      (aux_d),
      .mc_len_d   (mc_len_d),
      .valid_d    (valid_d),
      .stall_i    (stall_i),
      .flush_i    (flush_i),
      .sigs_q     (sigs_q),
      .aux_q      (aux_q),
      .valid_q    (valid_q),
      .stall_up_o (stall_up_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] stg(input int k);
      return {23'd0, sigs_q[k*9 +: 9]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [8:0] s, input logic v);
      sigs_d  = s;
      valid_d = v;
   endtask

   initial begin
      rst = 1'b0; sigs_d = '0; aux_d = '0; mc_len_d = '0; valid_d = 1'b0;
      stall_i = '0; flush_i = '0;
      #3;
      check("rst_valid", valid_q, 0);
      check("rst_sigs", sigs_q, 0);
      check("rst_aux", aux_q, 0);
      check("rst_busy", busy_o, 0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // free flow
      feed(9'h0A5, 1'b1); aux_d = 3'd5;
      tick();
      check("ff_s0", stg(0), 9'h0A5);
      check("ff_aux", aux_q, 5);
      check("ff_v1", valid_q, 3'b001);
      feed(9'h000, 1'b0); aux_d = 3'd0;
      tick();
      check("ff_s1", stg(1), 9'h0A5);
      check("ff_v2", valid_q, 3'b010);
      tick();
      check("ff_s2", stg(2), 9'h0A5);
      check("ff_v3", valid_q, 3'b100);
      check("ff_stallup", stall_up_o, 0);

      // mid stall with the pipe full
      feed(9'h011, 1'b1); tick();
      feed(9'h022, 1'b1); tick();
      feed(9'h033, 1'b1); tick();
      check("ms_full", valid_q, 3'b111);
      check("ms_s2A", stg(2), 9'h011);
      feed(9'h044, 1'b1); stall_i = 3'b010;
      #1;
      check("ms_stallup", stall_up_o, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("ms_s0", stg(0), 9'h033);
         check("ms_s1", stg(1), 9'h022);
         check("ms_s2bub", stg(2), 0);
         check("ms_valid", valid_q, 3'b011);
      end
      stall_i = 3'b000;
      tick();
      check("ms_res_s0", stg(0), 9'h044);
      check("ms_res_s1", stg(1), 9'h033);
      check("ms_res_s2", stg(2), 9'h022);
      feed(9'h000, 1'b0);

      // multi-cycle length 4
      feed(9'h100, 1'b1); mc_len_d = 6'd4;
      tick();
      check("mc_s0", stg(0), 9'h100);
      check("mc_busy1", busy_o, 1);
      check("mc_up1", stall_up_o, 1);
      feed(9'h055, 1'b1); mc_len_d = 6'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mc_hold_s0", stg(0), 9'h100);
         check("mc_s1bub", stg(1), 0);
         check("mc_v1bub", valid_q[1], 0);
         check("mc_busy", busy_o, (i < 2) ? 1 : 0);
         check("mc_up", stall_up_o, (i < 2) ? 1 : 0);
      end
      tick();
      check("mc_leave_s0", stg(0), 9'h055);
      check("mc_leave_s1", stg(1), 9'h100);
      check("mc_noarm", busy_o, 0);
      feed(9'h000, 1'b0);

      // length 1 behaves single-cycle
      feed(9'h1AA, 1'b1); mc_len_d = 6'd1;
      tick();
      check("len1_busy", busy_o, 0);
      check("len1_s0", stg(0), 9'h1AA);
      feed(9'h000, 1'b0); mc_len_d = 6'd0;
      tick();
      check("len1_s1", stg(1), 9'h1AA);

      // abort during BUSY at cnt==2
      feed(9'h100, 1'b1); mc_len_d = 6'd5;
      tick();
      check("ab_busy", busy_o, 1);
      feed(9'h066, 1'b1); mc_len_d = 6'd0;
      tick(); tick();
      flush_i = 3'b001;
      tick();
      check("ab_busy0", busy_o, 0);
      check("ab_v0", valid_q[0], 0);
      check("ab_s0", stg(0), 0);
      flush_i = 3'b000;
      tick();
      check("ab_next_s0", stg(0), 9'h066);
      check("ab_next_v0", valid_q[0], 1);
      feed(9'h000, 1'b0);
      tick(); tick(); tick();

      // flush and stall on stage 1 together
      feed(9'h0D1, 1'b1); tick();
      feed(9'h0E2, 1'b1); tick();
      feed(9'h0F3, 1'b1); flush_i = 3'b010; stall_i = 3'b010;
      #1;
      check("pr_up", stall_up_o, 1);
      tick();
      check("pr_s0", stg(0), 9'h0E2);
      check("pr_s1", stg(1), 0);
      check("pr_valid", valid_q, 3'b001);
      flush_i = '0; stall_i = '0; feed(9'h000, 1'b0);

      // async reset mid-BUSY
      feed(9'h1C0, 1'b1); mc_len_d = 6'd6; aux_d = 3'd3;
      tick();
      check("rb_busy", busy_o, 1);
      feed(9'h000, 1'b0); mc_len_d = 6'd0; aux_d = 3'd0;
      #2;
      rst = 1'b0;
      #1;
      check("rb_busy0", busy_o, 0);
      check("rb_sigs", sigs_q, 0);
      check("rb_valid", valid_q, 0);
      check("rb_aux", aux_q, 0);
      check("rb_up", stall_up_o, 0);
      tick();
      rst = 1'b1;
      tick();
      check("rr_busy", busy_o, 0);
      check("rr_up", stall_up_o, 0);
      stall_i = 3'b100;
      #1;
      check("rr_up_or", stall_up_o, 1);
      stall_i = 3'b000;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
